// File: rtl/blkram_copy.sv
// Word-by-word RAM-to-RAM copy engine: read one source word, write it to the destination, repeat.
// Optional fill mode (write a constant, no reads) is enabled by defining BLKCOPY_FILL_EN.
module blkram_copy (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [11:0] src_addr,
    input  logic [11:0] dst_addr,
    input  logic [11:0] len,
`ifdef BLKCOPY_FILL_EN
    input  logic        fill,
    input  logic [31:0] fill_data,
`endif
    output logic        busy,
    output logic        done,
    output logic        mem_select,
    output logic        mem_rd,
    output logic [3:0]  mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t      state;
    logic [11:0] src;
    logic [11:0] dst;
    logic [11:0] cnt;
    logic        fill_q;
    logic [31:0] fill_word;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            src       <= '0;
            dst       <= '0;
            cnt       <= '0;
            fill_q    <= 1'b0;
            fill_word <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != 12'd0) begin
                            src   <= src_addr;
                            dst   <= dst_addr;
                            cnt   <= len;
`ifdef BLKCOPY_FILL_EN
                            fill_q    <= fill;
                            fill_word <= fill_data;
                            state     <= fill ? WR : RD;
`else
                            fill_q    <= 1'b0;
                            fill_word <= '0;
                            state     <= RD;
`endif
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                RD: state <= WR;
                WR: begin
                    // Addresses wrap modulo 4096 by plain 12-bit overflow.
                    src <= src + 12'd1;
                    dst <= dst + 12'd1;
                    cnt <= cnt - 12'd1;
                    if (cnt == 12'd1) state <= FIN;
                    else              state <= fill_q ? WR : RD;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while resetn is held so an abort suppresses the in-flight write.
    always_comb begin
        busy       = 1'b0;
        done       = 1'b0;
        mem_select = 1'b0;
        mem_rd     = 1'b0;
        mem_we     = 4'h0;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (resetn) begin
            case (state)
                RD: begin
                    busy       = 1'b1;
                    mem_select = 1'b1;
                    mem_rd     = 1'b1;
                    mem_addr   = src;
                end
                WR: begin
                    busy       = 1'b1;
                    mem_select = 1'b1;
                    mem_we     = 4'hF;
                    mem_addr   = dst;
                    mem_wdata  = fill_q ? fill_word : mem_rdata;
                end
                FIN: done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
